// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU sequencer slice:
//     - default data width and register-file address width
//     - ALU operation encoding (the external ALU decodes alu_mode with it)
//     - sequencer FSM state type
//     - carry-select helper used when a command is accepted
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int NREG_LOG2_DEF = 3;

  // Operation codes presented on alu_mode.
  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_SHCL = 3'd3,
    MODE_SHCR = 3'd4,
    MODE_NOT  = 3'd5,
    MODE_SUB  = 3'd6,
    MODE_ADD  = 3'd7
  } alu_mode_e;

  // Sequencer states: operand latch (IDLE), ALU evaluation (EXEC),
  // register/flag write-back (WB).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_e;

  // Carry presented to the ALU: the live carry flag when the command asks
  // for it, otherwise zero.
  function automatic logic carry_sel(input logic use_carry, input logic flag_c);
    return use_carry & flag_c;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
//   Bundles every non-clock/reset signal of the ALU sequencer.
//     Command channel : cmd_valid/cmd_ready handshake, cmd_mode, cmd_dst,
//                       cmd_src_a, cmd_src_b, cmd_use_carry
//     Load port       : load_valid, load_addr, load_data (direct reg write)
//     Read port       : rd_addr -> rd_data (combinational)
//     ALU side        : alu_a, alu_b, alu_mode, alu_carry_in, alu_enable (n)
//                       out; alu_out, alu_carry_out back in
//     Status          : flag_c, flag_z, busy
//   modport slave  : the sequencer
//   modport master : the surrounding system (command source, loader, ALU)
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int NREG_LOG2 = 3
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_mode;
  logic [NREG_LOG2-1:0] cmd_dst;
  logic [NREG_LOG2-1:0] cmd_src_a;
  logic [NREG_LOG2-1:0] cmd_src_b;
  logic                 cmd_use_carry;

  logic                 load_valid;
  logic [NREG_LOG2-1:0] load_addr;
  logic [WIDTH-1:0]     load_data;

  logic [NREG_LOG2-1:0] rd_addr;
  logic [WIDTH-1:0]     rd_data;

  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [2:0]           alu_mode;
  logic                 alu_carry_in;
  logic                 alu_enable;
  logic [WIDTH-1:0]     alu_out;
  logic                 alu_carry_out;

  logic                 flag_c;
  logic                 flag_z;
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_carry,
    input  load_valid, load_addr, load_data,
    input  rd_addr,
    input  alu_out, alu_carry_out,
    output cmd_ready, rd_data,
    output alu_a, alu_b, alu_mode, alu_carry_in, alu_enable,
    output flag_c, flag_z, busy
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_carry,
    output load_valid, load_addr, load_data,
    output rd_addr,
    output alu_out, alu_carry_out,
    input  cmd_ready, rd_data,
    input  alu_a, alu_b, alu_mode, alu_carry_in, alu_enable,
    input  flag_c, flag_z, busy
  );

endinterface

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//   2**NREG_LOG2 x WIDTH register file.
//   Ports:
//     clk, rst_n          clock, synchronous active-low clear of all entries
//     load_en/addr/data   external load write
//     wb_en/addr/data     sequencer write-back
//     ra/rb/rc _addr/data three asynchronous read ports
//   Writes resolve per entry: when both writers hit the same entry the
//   write-back value lands; when they hit different entries both land.
//   Reset overrides both writers, so a load during reset is dropped.
// ---------------------------------------------------------------------------
module alu_regfile #(
  parameter int WIDTH     = 32,
  parameter int NREG_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic [NREG_LOG2-1:0] load_addr,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 wb_en,
  input  logic [NREG_LOG2-1:0] wb_addr,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic [NREG_LOG2-1:0] ra_addr,
  output logic [WIDTH-1:0]     ra_data,
  input  logic [NREG_LOG2-1:0] rb_addr,
  output logic [WIDTH-1:0]     rb_data,
  input  logic [NREG_LOG2-1:0] rc_addr,
  output logic [WIDTH-1:0]     rc_data
);

  localparam int NREG = 1 << NREG_LOG2;

  logic [WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_addr == NREG_LOG2'(i))) begin
          regs[i] <= wb_data;
        end else if (load_en && (load_addr == NREG_LOG2'(i))) begin
          regs[i] <= load_data;
        end
      end
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign rc_data = regs[rc_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Drives an external combinational ALU from a small register file.
//   A command is taken in IDLE (operands read from the register file and
//   registered onto alu_a/alu_b), the ALU is enabled for one EXEC cycle
//   while its result and carry are captured, and in WB the result is
//   written back and the carry/zero flags are updated.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (aborts any in-flight command)
//     bus    alu_sequencer_if.slave: command handshake, load port, read
//            port, ALU operand/result signals, flags and busy
//   Timing: accept at edge N, EXEC in cycle N..N+1, regfile and flags
//   written at edge N+2, next command can be accepted at edge N+3.
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NREG_LOG2 = NREG_LOG2_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);

  seq_state_e           state;

  // Destination latched with the operands.
  logic [NREG_LOG2-1:0] dst_p0;

  // ALU result captured at the end of EXEC, consumed in WB.
  logic [WIDTH-1:0]     res_p1;
  logic                 cout_p1;
  logic                 vld_p1;

  logic [WIDTH-1:0]     rf_a;
  logic [WIDTH-1:0]     rf_b;

  assign vld_p1 = (state == ST_WB);

  alu_regfile #(
    .WIDTH     (WIDTH),
    .NREG_LOG2 (NREG_LOG2)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (bus.load_valid),
    .load_addr (bus.load_addr),
    .load_data (bus.load_data),
    .wb_en     (vld_p1),
    .wb_addr   (dst_p0),
    .wb_data   (res_p1),
    .ra_addr   (bus.cmd_src_a),
    .ra_data   (rf_a),
    .rb_addr   (bus.cmd_src_b),
    .rb_data   (rf_b),
    .rc_addr   (bus.rd_addr),
    .rc_data   (bus.rd_data)
  );

  // cmd_ready, busy and alu_enable are kept as registers that change
  // together with the state, so every output leaves a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      bus.cmd_ready    <= 1'b1;
      bus.busy         <= 1'b0;
      bus.alu_enable   <= 1'b1;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.alu_mode     <= '0;
      bus.alu_carry_in <= 1'b0;
      bus.flag_c       <= 1'b0;
      bus.flag_z       <= 1'b0;
      dst_p0           <= '0;
      res_p1           <= '0;
      cout_p1          <= 1'b0;
    end else begin
      case (state)
        // Stage p0: operand latch. Register-file reads see pre-edge
        // contents, so a load landing on this same edge is not forwarded.
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            bus.alu_a        <= rf_a;
            bus.alu_b        <= rf_b;
            bus.alu_mode     <= bus.cmd_mode;
            bus.alu_carry_in <= carry_sel(bus.cmd_use_carry, bus.flag_c);
            dst_p0           <= bus.cmd_dst;
            bus.alu_enable   <= 1'b0;
            bus.cmd_ready    <= 1'b0;
            bus.busy         <= 1'b1;
            state            <= ST_EXEC;
          end
        end
        // Stage p1: ALU enabled for exactly this cycle; its combinational
        // result is sampled at the closing edge.
        ST_EXEC: begin
          res_p1         <= bus.alu_out;
          cout_p1        <= bus.alu_carry_out;
          bus.alu_enable <= 1'b1;
          state          <= ST_WB;
        end
        // Stage p2: write-back (register write happens in alu_regfile via
        // vld_p1) and flag update.
        ST_WB: begin
          bus.flag_c    <= cout_p1;
          bus.flag_z    <= (res_p1 == '0);
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          bus.cmd_ready  <= 1'b1;
          bus.busy       <= 1'b0;
          bus.alu_enable <= 1'b1;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Bench for alu_sequencer. Contains a behavioural ALU that answers the
//   sequencer while alu_enable is low, and a command-level reference model
//   (register array + carry/zero flags) that predicts every observable value.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int AW = 3;

  logic clk;
  logic rst_n;

  alu_sequencer_if #(.WIDTH(W), .NREG_LOG2(AW)) bus ();

  alu_sequencer #(.WIDTH(W), .NREG_LOG2(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [W-1:0] m_rf [8];
  logic         m_c;
  logic         m_z;

  // ALU behaviour: returns {carry, result}.
  function automatic logic [W:0] alu_fn(input logic [2:0] m, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic ci);
    logic [W:0] r;
    case (alu_mode_e'(m))
      MODE_AND:  r = {ci, a & b};
      MODE_OR:   r = {ci, a | b};
      MODE_XOR:  r = {ci, a ^ b};
      MODE_SHCL: r = {a[W-1], a[W-2:0], ci};
      MODE_SHCR: r = {a[0], ci, a[W-1:1]};
      MODE_NOT:  r = {ci, ~a};
      MODE_SUB:  r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      default:   r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endcase
    return r;
  endfunction

  // External ALU: only produces a result while enabled.
  always_comb begin
    {bus.alu_carry_out, bus.alu_out} = '0;
    if (!bus.alu_enable) begin
      {bus.alu_carry_out, bus.alu_out} =
        alu_fn(bus.alu_mode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [AW-1:0] addr);
    bus.rd_addr = addr;
    #1;
    chk(tag, 64'(bus.rd_data), 64'(m_rf[addr]));
  endtask

  task automatic check_const(input string tag, input logic [AW-1:0] addr, input logic [W-1:0] v);
    bus.rd_addr = addr;
    #1;
    chk(tag, 64'(bus.rd_data), 64'(v));
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [W-1:0] data);
    bus.load_valid = 1'b1;
    bus.load_addr  = addr;
    bus.load_data  = data;
    tick();
    bus.load_valid = 1'b0;
    m_rf[addr] = data;
  endtask

  // Issues one command and follows it to completion.
  // ld_phase: 0 none, 1 load on the accepting edge, 2 load on the WB edge.
  task automatic run_cmd(input string tag, input logic [2:0] mode, input logic [AW-1:0] dst,
                         input logic [AW-1:0] sa, input logic [AW-1:0] sb, input logic uc,
                         input int ld_phase, input logic [AW-1:0] ld_addr,
                         input logic [W-1:0] ld_data);
    logic [W-1:0] opa, opb;
    logic         ci;
    logic [W:0]   r;
    opa = m_rf[sa];
    opb = m_rf[sb];
    ci  = uc ? m_c : 1'b0;
    r   = alu_fn(mode, opa, opb, ci);

    chk($sformatf("%s_ready", tag), 64'(bus.cmd_ready), 64'(1'b1));
    bus.cmd_mode      = mode;
    bus.cmd_dst       = dst;
    bus.cmd_src_a     = sa;
    bus.cmd_src_b     = sb;
    bus.cmd_use_carry = uc;
    bus.cmd_valid     = 1'b1;
    if (ld_phase == 1) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = ld_addr;
      bus.load_data  = ld_data;
    end
    tick();
    bus.cmd_valid  = 1'b0;
    bus.load_valid = 1'b0;
    if (ld_phase == 1) m_rf[ld_addr] = ld_data;

    // EXEC cycle
    chk($sformatf("%s_exec_ops", tag), {bus.alu_a, bus.alu_b}, {opa, opb});
    chk($sformatf("%s_exec_ctl", tag),
        64'({bus.alu_mode, bus.alu_carry_in, bus.alu_enable, bus.busy, bus.cmd_ready}),
        64'({mode, ci, 1'b0, 1'b1, 1'b0}));
    tick();

    // WB cycle: nothing written yet
    chk($sformatf("%s_wb_ctl", tag),
        64'({bus.alu_enable, bus.busy, bus.cmd_ready}), 64'(3'b110));
    chk($sformatf("%s_wb_flags_old", tag), 64'({bus.flag_c, bus.flag_z}), 64'({m_c, m_z}));
    check_reg($sformatf("%s_wb_dst_old", tag), dst);
    if (ld_phase == 2) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = ld_addr;
      bus.load_data  = ld_data;
    end
    tick();
    bus.load_valid = 1'b0;

    // Back in IDLE: results visible
    if (ld_phase == 2) m_rf[ld_addr] = ld_data;
    m_rf[dst] = r[W-1:0];
    m_c = r[W];
    m_z = (r[W-1:0] == '0);
    chk($sformatf("%s_flags", tag), 64'({bus.flag_c, bus.flag_z}), 64'({m_c, m_z}));
    chk($sformatf("%s_idle_ctl", tag),
        64'({bus.alu_enable, bus.busy, bus.cmd_ready}), 64'(3'b101));
    chk($sformatf("%s_hold", tag), {bus.alu_a, bus.alu_b}, {opa, opb});
    check_reg($sformatf("%s_dst", tag), dst);
    if (ld_phase != 0 && ld_addr != dst) check_reg($sformatf("%s_ld", tag), ld_addr);
  endtask

  initial begin
    int pulses;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_dst = '0;
    bus.cmd_src_a = '0; bus.cmd_src_b = '0; bus.cmd_use_carry = 1'b0;
    bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.rd_addr = '0;
    model_clear();

    // Reset, with a load offered during reset that must be dropped.
    bus.load_valid = 1'b1; bus.load_addr = 3'd2; bus.load_data = 32'hDEAD_BEEF;
    tick(); tick();
    bus.load_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_ctl", 64'({bus.cmd_ready, bus.busy, bus.alu_enable, bus.flag_c, bus.flag_z}),
        64'(5'b10100));
    chk("rst_alu", 64'({bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_carry_in}), 64'(0));
    for (int i = 0; i < 8; i++) begin
      check_reg($sformatf("rst_r%0d", i), 3'(i));
      tick();
    end

    // Basic add
    load(3'd1, 32'h0000_0005);
    load(3'd2, 32'h0000_0003);
    run_cmd("add", 3'd7, 3'd3, 3'd1, 3'd2, 1'b0, 0, 3'd0, 32'h0);
    check_const("add_r3", 3'd3, 32'h0000_0008);
    chk("add_cz", 64'({bus.flag_c, bus.flag_z}), 64'(2'b00));

    // Overflow to zero, then carry consumed
    load(3'd1, 32'hFFFF_FFFF);
    load(3'd2, 32'h0000_0001);
    run_cmd("ovf", 3'd7, 3'd4, 3'd1, 3'd2, 1'b0, 0, 3'd0, 32'h0);
    check_const("ovf_r4", 3'd4, 32'h0);
    chk("ovf_cz", 64'({bus.flag_c, bus.flag_z}), 64'(2'b11));
    run_cmd("cin", 3'd7, 3'd5, 3'd0, 3'd0, 1'b1, 0, 3'd0, 32'h0);
    check_const("cin_r5", 3'd5, 32'h0000_0001);

    // Shifts through carry
    load(3'd7, 32'hFFFF_FFFF);
    run_cmd("setc", 3'd7, 3'd4, 3'd7, 3'd2, 1'b0, 0, 3'd0, 32'h0);
    load(3'd1, 32'h8000_0001);
    run_cmd("shcl", 3'd3, 3'd6, 3'd1, 3'd0, 1'b1, 0, 3'd0, 32'h0);
    check_const("shcl_r6", 3'd6, 32'h0000_0003);
    chk("shcl_c", 64'(bus.flag_c), 64'(1'b1));
    run_cmd("shcr", 3'd4, 3'd5, 3'd1, 3'd0, 1'b1, 0, 3'd0, 32'h0);
    check_const("shcr_r5", 3'd5, 32'hC000_0000);
    chk("shcr_c", 64'(bus.flag_c), 64'(1'b1));

    // Load colliding with write-back
    load(3'd1, 32'h0000_0005);
    load(3'd2, 32'h0000_0003);
    run_cmd("coll", 3'd7, 3'd3, 3'd1, 3'd2, 1'b0, 2, 3'd3, 32'h0000_1234);
    check_const("coll_r3", 3'd3, 32'h0000_0008);
    run_cmd("side", 3'd7, 3'd3, 3'd1, 3'd2, 1'b0, 2, 3'd6, 32'h0000_ABCD);
    check_const("side_r6", 3'd6, 32'h0000_ABCD);

    // Load on the accepting edge is not forwarded into the operands
    run_cmd("nobyp", 3'd6, 3'd4, 3'd1, 3'd2, 1'b0, 1, 3'd1, 32'h0000_0100);
    check_const("nobyp_r4", 3'd4, 32'h0000_0002);
    check_const("nobyp_r1", 3'd1, 32'h0000_0100);

    // Aliased source and destination registers
    run_cmd("alias", 3'd2, 3'd1, 3'd1, 3'd1, 1'b0, 0, 3'd0, 32'h0);
    check_const("alias_r1", 3'd1, 32'h0);

    // cmd_valid held high: one accept every third cycle
    load(3'd7, 32'h0F0F_0000);
    bus.cmd_mode = 3'd0; bus.cmd_dst = 3'd7; bus.cmd_src_a = 3'd7;
    bus.cmd_src_b = 3'd7; bus.cmd_use_carry = 1'b0;
    bus.cmd_valid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("stream_%0d", k), 64'({bus.cmd_ready, bus.busy, bus.alu_enable}),
          64'({(k % 3) == 0, (k % 3) != 0, (k % 3) != 1}));
      if (bus.cmd_ready) pulses++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    m_c = 1'b0;
    m_z = (m_rf[7] == '0);
    chk("stream_pulses", 64'(pulses), 64'(3));
    chk("stream_flags", 64'({bus.flag_c, bus.flag_z}), 64'({m_c, m_z}));
    check_reg("stream_r7", 3'd7);

    // Randomized commands against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) load(3'($urandom_range(0, 7)), $urandom);
      run_cmd($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
    end

    // Reset during EXEC of a SUB discards it
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    model_clear();
    load(3'd1, 32'h0000_0009);
    load(3'd3, 32'h0000_0004);
    bus.cmd_mode = 3'd6; bus.cmd_dst = 3'd2; bus.cmd_src_a = 3'd1;
    bus.cmd_src_b = 3'd3; bus.cmd_use_carry = 1'b0; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rexec_en", 64'(bus.alu_enable), 64'(1'b0));
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    model_clear();
    chk("rexec_ctl", 64'({bus.cmd_ready, bus.busy, bus.alu_enable, bus.flag_c, bus.flag_z}),
        64'(5'b10100));
    tick();
    chk("rexec_idle", 64'({bus.cmd_ready, bus.busy, bus.alu_enable}), 64'(3'b101));
    check_const("rexec_r2", 3'd2, 32'h0);

    // Reset during WB of an overflowing ADD discards it
    load(3'd1, 32'hFFFF_FFFF);
    load(3'd3, 32'h0000_0001);
    bus.cmd_mode = 3'd7; bus.cmd_dst = 3'd2; bus.cmd_src_a = 3'd1;
    bus.cmd_src_b = 3'd3; bus.cmd_use_carry = 1'b0; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    model_clear();
    tick();
    chk("rwb_flags", 64'({bus.flag_c, bus.flag_z}), 64'(2'b00));
    chk("rwb_ctl", 64'({bus.cmd_ready, bus.busy, bus.alu_enable}), 64'(3'b101));
    check_const("rwb_r1", 3'd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
